// File: rtl/vec_alu_sequencer_pkg.sv
// vec_alu_sequencer_pkg: ALU opcode encoding plus sequencer states and lane-counter sizing
package alu_defs;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_MOV = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SHR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_CMP = 3'd6;
    localparam logic [2:0] ALU_SUB = 3'd7;
endpackage

package vseq_defs;
    import alu_defs::*;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;
    function automatic int lane_w(input int lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction
endpackage

// File: rtl/vec_alu_sequencer_if.sv
// vec_alu_sequencer_if: instruction request / result bus (scalar_i only with VEC_SCALAR_BROADCAST_EN)
interface vec_alu_sequencer_if #(
    parameter int N = 8,
    parameter int LANES = 4
);
    logic                 start_i;
    logic [2:0]           opcode_i;
    logic [LANES*N-1:0]   va_i;
    logic [LANES*N-1:0]   vb_i;
    logic                 busy_o;
    logic                 done_o;
    logic [LANES*N-1:0]   vr_o;
    logic [LANES*2-1:0]   flags_o;
`ifdef VEC_SCALAR_BROADCAST_EN
    logic                 scalar_i;
    modport master (output start_i, opcode_i, va_i, vb_i, scalar_i, input busy_o, done_o, vr_o, flags_o);
    modport slave  (input start_i, opcode_i, va_i, vb_i, scalar_i, output busy_o, done_o, vr_o, flags_o);
`else
    modport master (output start_i, opcode_i, va_i, vb_i, input busy_o, done_o, vr_o, flags_o);
    modport slave  (input start_i, opcode_i, va_i, vb_i, output busy_o, done_o, vr_o, flags_o);
`endif
endinterface

// File: rtl/vec_alu_sequencer_lane_select.sv
// lane_select: combinational extraction of one N-bit element from a packed vector
module lane_select
    import vseq_defs::*;
#(
    parameter int N = 8,
    parameter int LANES = 4
) (
    input  logic [LANES*N-1:0]        vec,
    input  logic [lane_w(LANES)-1:0]  sel,
    output logic [N-1:0]              elem
);
    assign elem = vec[sel*N +: N];
endmodule

// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: runs one vector instruction through the scalar ALU a lane per cycle; option VEC_SCALAR_BROADCAST_EN
module vec_alu_sequencer
    import alu_defs::*;
    import vseq_defs::*;
#(
    parameter int N = 8,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst,
    vec_alu_sequencer_if.slave  bus,
    output logic [N-1:0]        alu_a_o,
    output logic [N-1:0]        alu_b_o,
    output logic [2:0]          alu_opcode_o,
    input  logic [N-1:0]        alu_result_i,
    input  logic [1:0]          alu_flags_i
);
    localparam int LW = lane_w(LANES);

    state_t             state;
    logic [LW-1:0]      cnt;
    logic [LW-1:0]      b_sel;
    logic [2:0]         op;
    logic [LANES*N-1:0] va;
    logic [LANES*N-1:0] vb;
    logic [LANES*N-1:0] vr;
    logic [LANES*2-1:0] flags;
    logic [N-1:0]       a_lane;
    logic [N-1:0]       b_lane;
    logic               run;
    logic               is_cmp;

`ifdef VEC_SCALAR_BROADCAST_EN
    logic               bcast;
    assign b_sel = bcast ? '0 : cnt;
`else
    assign b_sel = cnt;
`endif

    assign run    = state == RUN;
    assign is_cmp = op == ALU_CMP;

    lane_select #(.N(N), .LANES(LANES)) u_sel_a (.vec(va), .sel(cnt), .elem(a_lane));
    lane_select #(.N(N), .LANES(LANES)) u_sel_b (.vec(vb), .sel(b_sel), .elem(b_lane));

    assign alu_a_o      = run ? a_lane : '0;
    assign alu_b_o      = run ? b_lane : '0;
    assign alu_opcode_o = run ? op : ALU_ADD;

    assign bus.busy_o  = state != IDLE;
    assign bus.done_o  = state == DONE;
    assign bus.vr_o    = vr;
    assign bus.flags_o = flags;

    // FSM: accept in IDLE, capture one lane per RUN cycle, single DONE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            va    <= '0;
            vb    <= '0;
            vr    <= '0;
            flags <= '0;
`ifdef VEC_SCALAR_BROADCAST_EN
            bcast <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    state <= RUN;
                    cnt   <= '0;
                    op    <= bus.opcode_i;
                    va    <= bus.va_i;
                    vb    <= bus.vb_i;
`ifdef VEC_SCALAR_BROADCAST_EN
                    bcast <= bus.scalar_i;
`endif
                end
                RUN: begin
                    vr[cnt*N +: N]    <= is_cmp ? a_lane : alu_result_i;
                    flags[cnt*2 +: 2] <= is_cmp ? alu_flags_i : 2'b00;
                    if (cnt == LW'(LANES-1)) state <= DONE;
                    else cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vec_alu_sequencer.sv
// tb_vec_alu_sequencer: scoreboard bench for vec_alu_sequencer with a behavioural ALU (option VEC_SCALAR_BROADCAST_EN)
module tb_vec_alu_sequencer;
    import alu_defs::*;

    localparam int N = 8;
    localparam int LANES = 4;

    typedef struct {
        logic [31:0] vr;
        logic [7:0]  fl;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] alu_a, alu_b, alu_res, alu_d;
    logic [2:0] alu_op;
    logic [1:0] alu_fl;
    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    vec_alu_sequencer_if #(.N(N), .LANES(LANES)) bus ();

    vec_alu_sequencer #(.N(N), .LANES(LANES)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_op),
        .alu_result_i(alu_res), .alu_flags_i(alu_fl)
    );

    always #5 clk = ~clk;

    // external ALU stand-in; non-CMP flags are deliberately junk
    always_comb begin
        alu_d = alu_a - alu_b;
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_MOV: alu_res = alu_b;
            ALU_XOR: alu_res = alu_a ^ alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_SHR: alu_res = alu_a >> alu_b;
            ALU_SHL: alu_res = alu_a << alu_b;
            default: alu_res = alu_d;
        endcase
        alu_fl = (alu_op == ALU_CMP) ? {alu_d[7], alu_d == 8'd0} : 2'b11;
    end

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sc);
        exp_t e;
        logic [7:0] ai, bi, d, r;
        e.vr = '0;
        e.fl = '0;
        for (int i = 0; i < LANES; i++) begin
            ai = a[i*8 +: 8];
            bi = sc ? b[7:0] : b[i*8 +: 8];
            d  = ai - bi;
            case (op)
                ALU_ADD: r = ai + bi;
                ALU_MOV: r = bi;
                ALU_XOR: r = ai ^ bi;
                ALU_OR:  r = ai | bi;
                ALU_SHR: r = ai >> bi;
                ALU_SHL: r = ai << bi;
                ALU_CMP: r = ai;
                default: r = d;
            endcase
            e.vr[i*8 +: 8] = r;
            if (op == ALU_CMP) e.fl[i*2 +: 2] = {d[7], d == 8'd0};
        end
        return e;
    endfunction

    task automatic drive_scalar(input logic sc);
`ifdef VEC_SCALAR_BROADCAST_EN
        bus.scalar_i = sc;
`else
        if (sc) $display("[TB] scalar request ignored in default build");
`endif
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic sc, input bit pulse);
        exp_t e;
        int cyc;
        @(negedge clk);
        bus.start_i = 1'b1; bus.opcode_i = op; bus.va_i = a; bus.vb_i = b;
        drive_scalar(sc);
        sb.push_back(model(op, a, b, sc));
        @(negedge clk);
        cyc = 1;
        tests++;
        if (alu_op !== op || alu_a !== a[7:0]) begin
            fails++;
            $display("FAIL %s alu lane0: op=%0d a=%h, required op=%0d a=%h", name, alu_op, alu_a, op, a[7:0]);
        end
        bus.start_i = 1'b0; bus.opcode_i = 3'($urandom); bus.va_i = $urandom; bus.vb_i = $urandom;
        while (!bus.done_o && cyc < 20) begin
            if (pulse && cyc == 2) bus.start_i = 1'b1;
            @(negedge clk);
            bus.start_i = 1'b0;
            cyc++;
        end
        e = sb.pop_front();
        tests++;
        if (cyc !== LANES + 1) begin
            fails++;
            $display("FAIL %s latency: done in cycle %0d, required %0d", name, cyc, LANES + 1);
        end
        tests++;
        if (bus.vr_o !== e.vr || bus.flags_o !== e.fl || bus.busy_o !== 1'b1) begin
            fails++;
            $display("FAIL %s result: vr=%h flags=%b busy=%b, required vr=%h flags=%b busy=1", name, bus.vr_o, bus.flags_o, bus.busy_o, e.vr, e.fl);
        end
        if (pulse) bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        tests++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || alu_a !== 8'd0 || alu_op !== 3'd0) begin
            fails++;
            $display("FAIL %s after done: done=%b busy=%b alu_a=%h alu_op=%0d, required all 0", name, bus.done_o, bus.busy_o, alu_a, alu_op);
        end
        tests++;
        if (bus.vr_o !== e.vr || bus.flags_o !== e.fl) begin
            fails++;
            $display("FAIL %s hold: vr=%h flags=%b, required vr=%h flags=%b", name, bus.vr_o, bus.flags_o, e.vr, e.fl);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.vr_o !== 32'd0 || bus.flags_o !== 8'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || alu_op !== 3'd0) begin
            fails++;
            $display("FAIL reset: busy=%b done=%b vr=%h flags=%b alu=%h/%h/%0d, required all 0", bus.busy_o, bus.done_o, bus.vr_o, bus.flags_o, alu_a, alu_b, alu_op);
        end
    endtask

    task automatic test_add();
        run_op("add", ALU_ADD, 32'h04030201, 32'h10101010, 1'b0, 1'b0);
    endtask

    task automatic test_cmp();
        run_op("cmp", ALU_CMP, 32'h00070080, 32'h00080000, 1'b0, 1'b0);
    endtask

    task automatic test_shl();
        run_op("shl", ALU_SHL, 32'h814001FF, 32'h01010300, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        int dones;
        run_op("sub_ignore", ALU_SUB, 32'h00000000, 32'h01010101, 1'b0, 1'b1);
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL ignore_start extra activity: %0d cycles, required 0", dones);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(negedge clk);
        bus.start_i = 1'b1; bus.opcode_i = ALU_ADD; bus.va_i = 32'h11223344; bus.vb_i = 32'h01010101;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.vr_o !== 32'd0 || bus.flags_o !== 8'd0 || alu_a !== 8'd0) begin
            fails++;
            $display("FAIL mid_run_reset: busy=%b done=%b vr=%h flags=%b alu_a=%h, required all 0", bus.busy_o, bus.done_o, bus.vr_o, bus.flags_o, alu_a);
        end
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL mid_run_reset done pulses: %0d, required 0", dones);
        end
        run_op("add_after_reset", ALU_ADD, 32'h04030201, 32'h10101010, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_or", ALU_OR, 32'hA0B0C0D0, 32'h0A0B0C0D, 1'b0, 1'b0);
        run_op("b2b_mov", ALU_MOV, 32'hDEADBEEF, 32'h5A5AA5A5, 1'b0, 1'b0);
        run_op("b2b_shr", ALU_SHR, 32'h80FF0F01, 32'h07040100, 1'b0, 1'b0);
    endtask

    task automatic test_broadcast();
`ifdef VEC_SCALAR_BROADCAST_EN
        run_op("xor_bcast", ALU_XOR, 32'h0FF0AA55, 32'h000000FF, 1'b1, 1'b0);
        run_op("shl_bcast", ALU_SHL, 32'h01020304, 32'h07060502, 1'b1, 1'b0);
`else
        run_op("xor_vec", ALU_XOR, 32'h0FF0AA55, 32'h000000FF, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        bus.start_i = 1'b0; bus.opcode_i = '0; bus.va_i = '0; bus.vb_i = '0;
        drive_scalar(1'b0);
        test_reset();
        test_add();
        test_cmp();
        test_shl();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_broadcast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
